vid_mem_arbiter: RTL and testbench

- Shares the single 256-bit memory data port between two requesters:
  - the display frame fetcher, read-only, which feeds the pixel FIFO;
  - the host/render port, read and write.
- Sits between those requesters and the memory controller, on the 100 MHz memory-side clock domain.
- Priority: urgent display requests win, otherwise grants are round-robin, and a starvation limit protects the host.
- Only one memory transaction is outstanding at any time.

---
 rtl/vid_mem_arbiter_pkg.sv | 18 +
 rtl/vid_mem_arbiter_pick.sv | 39 +++
 rtl/vid_mem_arbiter.sv | 170 +++++++++++++++++
 tb/tb_vid_mem_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vid_mem_arbiter_pkg.sv
// Shared definitions for the video memory arbiter: FSM states, requester
// IDs and the memory read/write polarity.
package vid_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } arb_state_e;

  typedef enum logic {
    REQ_DISP = 1'b0,
    REQ_HOST = 1'b1
  } req_id_e;

  localparam logic MEM_READ = 1'b1;

endpackage

// File: rtl/vid_mem_arbiter_pick.sv
// vid_arb_pick: combinational grant decision for the video memory arbiter.
// Ports:
//   disp_valid, disp_urgent, host_valid : current requests
//   rr_ptr                              : round-robin pointer (preferred requester)
//   starve_cnt                          : consecutive host losses
//   winner                              : chosen requester (meaningful when grant=1)
//   grant                               : at least one request is valid
module vid_arb_pick
  import vid_mem_arbiter_pkg::*;
#(
  parameter int unsigned HOST_MAX_WAIT = 4,
  parameter int unsigned CNT_W         = 3
) (
  input  logic             disp_valid,
  input  logic             disp_urgent,
  input  logic             host_valid,
  input  req_id_e          rr_ptr,
  input  logic [CNT_W-1:0] starve_cnt,
  output req_id_e          winner,
  output logic             grant
);

  localparam logic [CNT_W-1:0] MAX_WAIT = CNT_W'(HOST_MAX_WAIT);

  always_comb begin
    winner = rr_ptr;
    grant  = disp_valid | host_valid;
    if (host_valid && (starve_cnt >= MAX_WAIT)) begin
      winner = REQ_HOST;
    end else if (disp_valid && disp_urgent) begin
      winner = REQ_DISP;
    end else if (rr_ptr == REQ_HOST) begin
      winner = host_valid ? REQ_HOST : REQ_DISP;
    end else begin
      winner = disp_valid ? REQ_DISP : REQ_HOST;
    end
  end

endmodule

// File: rtl/vid_mem_arbiter.sv
// vid_mem_arbiter: shares one memory data port between the display fetcher
// (read-only) and the host port (read/write). One transaction in flight,
// all outputs registered.
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   disp_valid/urgent/addr        : display read request, held until disp_ack
//   disp_ack, disp_rdata          : display completion pulse and read data
//   host_valid/rw/addr/wdata      : host request, held until host_ack
//   host_ack, host_rdata          : host completion pulse and read data
//   mem_valid_data, mem_rw_data,
//   mem_data_addr, data_wr        : request to the memory controller
//   data_rd, mem_ready_data       : memory read data and completion
module vid_mem_arbiter
  import vid_mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W        = 28,
  parameter int unsigned DATA_W        = 256,
  parameter int unsigned HOST_MAX_WAIT = 4,
  parameter int unsigned CNT_W         = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              disp_valid,
  input  logic              disp_urgent,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_ack,
  output logic [DATA_W-1:0] disp_rdata,
  input  logic              host_valid,
  input  logic              host_rw,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ack,
  output logic [DATA_W-1:0] host_rdata,
  output logic              mem_valid_data,
  output logic              mem_rw_data,
  output logic [ADDR_W-1:0] mem_data_addr,
  output logic [DATA_W-1:0] data_wr,
  input  logic [DATA_W-1:0] data_rd,
  input  logic              mem_ready_data
);

  arb_state_e        state_q, state_d;
  req_id_e           rr_ptr_q, rr_ptr_d;
  req_id_e           owner_q, owner_d;
  logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
  logic              mem_valid_q, mem_valid_d;
  logic              mem_rw_q, mem_rw_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              disp_ack_q, disp_ack_d;
  logic              host_ack_q, host_ack_d;
  logic [DATA_W-1:0] disp_rdata_q, disp_rdata_d;
  logic [DATA_W-1:0] host_rdata_q, host_rdata_d;

  req_id_e           winner;
  logic              grant;

  vid_arb_pick #(
    .HOST_MAX_WAIT(HOST_MAX_WAIT),
    .CNT_W        (CNT_W)
  ) u_pick (
    .disp_valid (disp_valid),
    .disp_urgent(disp_urgent),
    .host_valid (host_valid),
    .rr_ptr     (rr_ptr_q),
    .starve_cnt (starve_cnt_q),
    .winner     (winner),
    .grant      (grant)
  );

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    owner_d      = owner_q;
    starve_cnt_d = starve_cnt_q;
    mem_valid_d  = mem_valid_q;
    mem_rw_d     = mem_rw_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    disp_ack_d   = 1'b0;
    host_ack_d   = 1'b0;
    disp_rdata_d = disp_rdata_q;
    host_rdata_d = host_rdata_q;

    unique case (state_q)
      IDLE: begin
        if (grant) begin
          owner_d     = winner;
          mem_valid_d = 1'b1;
          state_d     = ISSUE;
          if (winner == REQ_HOST) begin
            mem_rw_d     = host_rw;
            mem_addr_d   = host_addr;
            mem_wdata_d  = host_wdata;
            starve_cnt_d = '0;
            rr_ptr_d     = REQ_DISP;
          end else begin
            mem_rw_d    = MEM_READ;
            mem_addr_d  = disp_addr;
            mem_wdata_d = '0;
            rr_ptr_d    = REQ_HOST;
            // Host lost this round while waiting; saturate rather than wrap.
            if (host_valid && (starve_cnt_q != '1)) begin
              starve_cnt_d = starve_cnt_q + CNT_W'(1);
            end
          end
        end
      end
      ISSUE: begin
        if (mem_ready_data) begin
          mem_valid_d = 1'b0;
          state_d     = RESP;
          if (owner_q == REQ_HOST) begin
            host_ack_d = 1'b1;
            if (mem_rw_q == MEM_READ) host_rdata_d = data_rd;
          end else begin
            disp_ack_d = 1'b1;
            if (mem_rw_q == MEM_READ) disp_rdata_d = data_rd;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      rr_ptr_q     <= REQ_HOST;
      owner_q      <= REQ_DISP;
      starve_cnt_q <= '0;
      mem_valid_q  <= 1'b0;
      mem_rw_q     <= MEM_READ;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      disp_ack_q   <= 1'b0;
      host_ack_q   <= 1'b0;
      disp_rdata_q <= '0;
      host_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      owner_q      <= owner_d;
      starve_cnt_q <= starve_cnt_d;
      mem_valid_q  <= mem_valid_d;
      mem_rw_q     <= mem_rw_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      disp_ack_q   <= disp_ack_d;
      host_ack_q   <= host_ack_d;
      disp_rdata_q <= disp_rdata_d;
      host_rdata_q <= host_rdata_d;
    end
  end

  assign mem_valid_data = mem_valid_q;
  assign mem_rw_data    = mem_rw_q;
  assign mem_data_addr  = mem_addr_q;
  assign data_wr        = mem_wdata_q;
  assign disp_ack       = disp_ack_q;
  assign host_ack       = host_ack_q;
  assign disp_rdata     = disp_rdata_q;
  assign host_rdata     = host_rdata_q;

endmodule

// File: tb/tb_vid_mem_arbiter.sv
module tb_vid_mem_arbiter;

  localparam int unsigned AW = 28;
  localparam int unsigned DW = 256;

  logic          clk = 1'b0;
  logic          rst;
  logic          disp_valid, disp_urgent, disp_ack;
  logic [AW-1:0] disp_addr;
  logic [DW-1:0] disp_rdata;
  logic          host_valid, host_rw, host_ack;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata, host_rdata;
  logic          mem_valid_data, mem_rw_data, mem_ready_data;
  logic [AW-1:0] mem_data_addr;
  logic [DW-1:0] data_wr, data_rd;

  always #5 clk = ~clk;

  vid_mem_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .HOST_MAX_WAIT(4), .CNT_W(3)
  ) dut (
    .clk(clk), .rst(rst),
    .disp_valid(disp_valid), .disp_urgent(disp_urgent), .disp_addr(disp_addr),
    .disp_ack(disp_ack), .disp_rdata(disp_rdata),
    .host_valid(host_valid), .host_rw(host_rw), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_ack(host_ack), .host_rdata(host_rdata),
    .mem_valid_data(mem_valid_data), .mem_rw_data(mem_rw_data),
    .mem_data_addr(mem_data_addr), .data_wr(data_wr), .data_rd(data_rd),
    .mem_ready_data(mem_ready_data)
  );

  typedef struct {
    logic          host;
    logic          rw;
    logic          urg;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } req_t;

  typedef struct {
    req_t r;
    int   delay;
    int   lat;
  } vec_t;

  req_t disp_q[$];
  req_t host_q[$];
  req_t exp_q[$];
  req_t cur;
  vec_t vecs[6];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit rst_s = 1'b0;
  bit rdy_s = 1'b0;
  bit active = 1'b0;
  bit spur = 1'b0;
  int wait_cnt = 0;
  int rdy_delay = 0;
  int issue_cyc = 0, host_ack_cyc = 0, disp_ack_cyc = 0;
  int host_req_cyc = 0, disp_req_cyc = 0;
  logic [DW-1:0] sh_disp = '0;
  logic [DW-1:0] sh_host = '0;

  function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] a);
    logic [31:0] w;
    w = ({4'h0, a} * 32'h9E3779B1) ^ 32'hC3C30000;
    return {8{w}};
  endfunction

  function automatic req_t mk(input logic host, input logic rw, input logic urg,
                              input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    req_t r;
    r.host = host; r.rw = rw; r.urg = urg; r.addr = addr; r.wdata = wdata;
    return r;
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic enq(input req_t r);
    if (r.host) host_q.push_back(r);
    else disp_q.push_back(r);
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || active || disp_q.size() != 0 || host_q.size() != 0) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 300) begin
      checks++;
      errors++;
      $display("FAIL %s: timeout with %0d grants still expected", name, exp_q.size());
      exp_q.delete(); disp_q.delete(); host_q.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    cyc++;
    rst_s = rst;
    rdy_s = mem_ready_data;
  end

  // Scoreboard monitor, requester model and memory model.
  always @(negedge clk) begin
    bit fin;
    fin = 1'b0;
    if (rst_s) begin
      active  = 1'b0;
      sh_disp = '0;
      sh_host = '0;
      chk("rst_mem_valid", DW'(mem_valid_data), '0);
      chk("rst_rw", DW'(mem_rw_data), DW'(1'b1));
      chk("rst_addr", DW'(mem_data_addr), '0);
      chk("rst_wdata", data_wr, '0);
      chk("rst_acks", DW'({disp_ack, host_ack}), '0);
      chk("rst_disp_rdata", disp_rdata, '0);
      chk("rst_host_rdata", host_rdata, '0);
    end else if (active && rdy_s) begin
      fin    = 1'b1;
      active = 1'b0;
    end

    if (fin) begin
      chk("ack_owner", DW'({disp_ack, host_ack}), cur.host ? DW'(2'b01) : DW'(2'b10));
      chk("ack_mem_valid_low", DW'(mem_valid_data), '0);
      if (cur.rw) begin
        if (cur.host) sh_host = mem_fn(cur.addr);
        else sh_disp = mem_fn(cur.addr);
      end
      chk("host_rdata", host_rdata, sh_host);
      chk("disp_rdata", disp_rdata, sh_disp);
      if (cur.host) host_ack_cyc = cyc;
      else disp_ack_cyc = cyc;
    end else if (!rst_s && (disp_ack || host_ack)) begin
      checks++;
      errors++;
      $display("FAIL unexpected_ack: got disp=%b host=%b expected none", disp_ack, host_ack);
    end

    if (!rst_s && !fin) begin
      if (active) begin
        chk("hold_valid", DW'(mem_valid_data), DW'(1'b1));
        chk("hold_rw", DW'(mem_rw_data), DW'(cur.rw));
        chk("hold_addr", DW'(mem_data_addr), DW'(cur.addr));
        chk("hold_wdata", data_wr, cur.wdata);
      end else if (mem_valid_data) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_request: got addr %h expected no request", mem_data_addr);
        end else begin
          cur = exp_q.pop_front();
          chk("req_rw", DW'(mem_rw_data), DW'(cur.rw));
          chk("req_addr", DW'(mem_data_addr), DW'(cur.addr));
          chk("req_wdata", data_wr, cur.wdata);
          active    = 1'b1;
          wait_cnt  = 0;
          issue_cyc = cyc;
        end
      end
    end

    if (disp_ack && disp_q.size() > 0) disp_q.delete(0);
    if (host_ack && host_q.size() > 0) host_q.delete(0);

    if (disp_q.size() > 0) begin
      if (!disp_valid || disp_ack) disp_req_cyc = cyc;
      disp_valid  = 1'b1;
      disp_urgent = disp_q[0].urg;
      disp_addr   = disp_q[0].addr;
    end else begin
      disp_valid = 1'b0; disp_urgent = 1'b0; disp_addr = '0;
    end
    if (host_q.size() > 0) begin
      if (!host_valid || host_ack) host_req_cyc = cyc;
      host_valid = 1'b1;
      host_rw    = host_q[0].rw;
      host_addr  = host_q[0].addr;
      host_wdata = host_q[0].wdata;
    end else begin
      host_valid = 1'b0; host_rw = 1'b1; host_addr = '0; host_wdata = '0;
    end

    data_rd = mem_fn(mem_data_addr);
    if (active) begin
      mem_ready_data = (wait_cnt >= rdy_delay);
      wait_cnt++;
    end else begin
      mem_ready_data = spur;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    disp_valid = 1'b0; disp_urgent = 1'b0; disp_addr = '0;
    host_valid = 1'b0; host_rw = 1'b1; host_addr = '0; host_wdata = '0;
    data_rd = '0; mem_ready_data = 1'b0;

    vecs[0] = '{r: mk(1'b1, 1'b1, 1'b0, 28'h0001234, {DW{1'b0}}), delay: 0, lat: 1};
    vecs[1] = '{r: mk(1'b1, 1'b0, 1'b0, 28'h0001235, {8{32'hDEADBEEF}}), delay: 2, lat: 3};
    vecs[2] = '{r: mk(1'b0, 1'b1, 1'b1, 28'h0FFFFFF, {DW{1'b0}}), delay: 0, lat: 1};
    vecs[3] = '{r: mk(1'b0, 1'b1, 1'b0, 28'h0000000, {DW{1'b0}}), delay: 10, lat: 11};
    vecs[4] = '{r: mk(1'b1, 1'b1, 1'b0, 28'hFFFFFFF, {DW{1'b0}}), delay: 1, lat: 2};
    vecs[5] = '{r: mk(1'b1, 1'b0, 1'b0, 28'h0000000, {DW{1'b0}}), delay: 0, lat: 1};

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Idle after reset, then a lone display read with immediate ready.
    repeat (2) begin
      @(posedge clk); #1;
      chk("idle_mem_valid", DW'(mem_valid_data), '0);
    end
    rdy_delay = 0;
    enq(mk(1'b0, 1'b1, 1'b0, 28'h0000100, {DW{1'b0}}));
    exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 28'h0000100, {DW{1'b0}}));
    wait_done("first_disp");
    chk_int("issue_latency", issue_cyc - disp_req_cyc, 1);
    chk_int("ack_latency", disp_ack_cyc - disp_req_cyc, 2);

    // Simultaneous requests, pointer at host: host write first, then display.
    enq(mk(1'b1, 1'b0, 1'b0, 28'h0ABCDEF, {DW{1'b1}}));
    enq(mk(1'b0, 1'b1, 1'b0, 28'h0000200, {DW{1'b0}}));
    exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 28'h0ABCDEF, {DW{1'b1}}));
    exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 28'h0000200, {DW{1'b0}}));
    wait_done("simultaneous");
    chk_int("ack_spacing", disp_ack_cyc - host_ack_cyc, 3);

    // Single-requester vectors with varying memory latency.
    foreach (vecs[i]) begin
      rdy_delay = vecs[i].delay;
      enq(vecs[i].r);
      exp_q.push_back(vecs[i].r);
      wait_done("vector");
      chk_int("vec_latency", (vecs[i].r.host ? host_ack_cyc : disp_ack_cyc) - issue_cyc, vecs[i].lat);
    end
    rdy_delay = 0;

    // Urgent display vs waiting host: four display grants, then host.
    for (int i = 0; i < 8; i++) enq(mk(1'b0, 1'b1, 1'b1, AW'(32'h300 + i), {DW{1'b0}}));
    enq(mk(1'b1, 1'b1, 1'b0, 28'h0000400, {DW{1'b0}}));
    enq(mk(1'b1, 1'b1, 1'b0, 28'h0000401, {DW{1'b0}}));
    for (int i = 0; i < 4; i++) exp_q.push_back(mk(1'b0, 1'b1, 1'b1, AW'(32'h300 + i), {DW{1'b0}}));
    exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 28'h0000400, {DW{1'b0}}));
    for (int i = 4; i < 8; i++) exp_q.push_back(mk(1'b0, 1'b1, 1'b1, AW'(32'h300 + i), {DW{1'b0}}));
    exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 28'h0000401, {DW{1'b0}}));
    wait_done("starvation");

    // Reset mid-transaction: host grant abandoned, pointer back at host.
    rdy_delay = 50;
    enq(mk(1'b1, 1'b1, 1'b0, 28'h0000500, {DW{1'b0}}));
    exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 28'h0000500, {DW{1'b0}}));
    begin
      int n;
      n = 0;
      while (!active && n < 20) begin
        @(posedge clk); #1;
        n++;
      end
      chk_int("reset_test_issued", int'(active), 1);
    end
    enq(mk(1'b0, 1'b1, 1'b0, 28'h0000600, {DW{1'b0}}));
    exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 28'h0000500, {DW{1'b0}}));
    exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 28'h0000600, {DW{1'b0}}));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rdy_delay = 0;
    wait_done("reset_issue");

    // Spurious ready while idle.
    spur = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      chk("spur_mem_valid", DW'(mem_valid_data), '0);
      chk("spur_acks", DW'({disp_ack, host_ack}), '0);
    end
    spur = 1'b0;
    enq(mk(1'b1, 1'b1, 1'b0, 28'h0000700, {DW{1'b0}}));
    exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 28'h0000700, {DW{1'b0}}));
    wait_done("after_spur");
    chk_int("post_spur_issue_latency", issue_cyc - host_req_cyc, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
